// File: rtl/fifo_pkg.sv
// Shared constants, operation encoding and width helpers for the synchronous FIFO family.
// The optional sticky error flags in sync_fifo are enabled with the SYNC_FIFO_ERR_EN macro.
package fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 256;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_PUSH_POP
    } fifoOp_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // One extra bit beyond the address so full and empty stay distinguishable.
    function automatic int ptrWidth(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_W register array with one write port and one registered read port.
// The array itself is never cleared; only the read register returns to zero on reset.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic              i_rdEn,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdData;

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Read register holds its last value whenever no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdData <= '0;
        end else if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, registered status flags and registered read port.
// Defining SYNC_FIFO_ERR_EN adds err_clr plus sticky overflow/underflow flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter  int DATA_W    = DEFAULT_DATA_W,
    parameter  int DEPTH     = DEFAULT_DEPTH,
    parameter  int AFULL_TH  = DEPTH - 4,
    parameter  int AEMPTY_TH = 4,
    localparam int ADDR_W    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count
`ifdef SYNC_FIFO_ERR_EN
    ,
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int PTR_W = ptrWidth(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0] FULL_CNT   = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_CNT  = PTR_W'(AFULL_TH);
    localparam logic [PTR_W-1:0] AEMPTY_CNT = PTR_W'(AEMPTY_TH);

    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] w_wrPtrNext;
    logic [PTR_W-1:0] w_rdPtrNext;
    logic [PTR_W-1:0] w_countNext;
    logic             w_wrAccept;
    logic             w_rdAccept;
    fifoOp_e          w_op;

    logic r_full;
    logic r_empty;
    logic r_almostFull;
    logic r_almostEmpty;
    logic r_rdValid;

    // Acceptance uses the flags registered at the start of the cycle; reset overrides both requests.
    assign w_wrAccept = !rst && wr_en && !r_full;
    assign w_rdAccept = !rst && rd_en && !r_empty;

    always_comb begin
        w_op        = OP_IDLE;
        w_wrPtrNext = r_wrPtr;
        w_rdPtrNext = r_rdPtr;
        case ({w_wrAccept, w_rdAccept})
            2'b10:   w_op = OP_PUSH;
            2'b01:   w_op = OP_POP;
            2'b11:   w_op = OP_PUSH_POP;
            default: w_op = OP_IDLE;
        endcase
        case (w_op)
            OP_PUSH:     w_wrPtrNext = r_wrPtr + PTR_ONE;
            OP_POP:      w_rdPtrNext = r_rdPtr + PTR_ONE;
            OP_PUSH_POP: begin
                w_wrPtrNext = r_wrPtr + PTR_ONE;
                w_rdPtrNext = r_rdPtr + PTR_ONE;
            end
            default: ;
        endcase
        w_countNext = w_wrPtrNext - w_rdPtrNext;
    end

    // Flags derive from the next-state occupancy so they line up with count in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almostFull  <= 1'b0;
            r_almostEmpty <= 1'b1;
            r_rdValid     <= 1'b0;
        end else begin
            r_wrPtr       <= w_wrPtrNext;
            r_rdPtr       <= w_rdPtrNext;
            r_full        <= (w_countNext == FULL_CNT);
            r_empty       <= (w_countNext == '0);
            r_almostFull  <= (w_countNext >= AFULL_CNT);
            r_almostEmpty <= (w_countNext <= AEMPTY_CNT);
            r_rdValid     <= w_rdAccept;
        end
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .i_wrEn   (w_wrAccept),
        .i_wrAddr (r_wrPtr[ADDR_W-1:0]),
        .i_wrData (wr_data),
        .i_rdEn   (w_rdAccept),
        .i_rdAddr (r_rdPtr[ADDR_W-1:0]),
        .o_rdData (rd_data)
    );

    assign count        = r_wrPtr - r_rdPtr;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almostFull;
    assign almost_empty = r_almostEmpty;
    assign rd_valid     = r_rdValid;

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    // Without error tracking, rejected requests simply leave no trace.
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed corner cases plus randomized traffic
// compared against a queue-based reference model (error flags checked when SYNC_FIFO_ERR_EN is set).
module tb_sync_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [8:0]        count;
`ifdef SYNC_FIFO_ERR_EN
    logic              err_clr;
    logic              overflow;
    logic              underflow;
    bit                modelOvf;
    bit                modelUnf;
`endif

    int numChecks = 0;
    int numErrors = 0;

    // Reference model: a plain queue holds the stored words in arrival order.
    logic [DATA_W-1:0] modelQ[$];
    logic [DATA_W-1:0] lastData;
    bit                expValid;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_TH  (DEPTH - 4),
        .AEMPTY_TH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Compare every output against what the queue model implies.
    task automatic checkAll(input string tag);
        int n;
        n = modelQ.size();
        checkOutput({tag, ".count"},        32'(count),        32'(n));
        checkOutput({tag, ".full"},         32'(full),         32'(n == DEPTH));
        checkOutput({tag, ".empty"},        32'(empty),        32'(n == 0));
        checkOutput({tag, ".almost_full"},  32'(almost_full),  32'(n >= DEPTH - 4));
        checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 4));
        checkOutput({tag, ".rd_valid"},     32'(rd_valid),     32'(expValid));
        checkOutput({tag, ".rd_data"},      32'(rd_data),      32'(lastData));
`ifdef SYNC_FIFO_ERR_EN
        checkOutput({tag, ".overflow"},     32'(overflow),     32'(modelOvf));
        checkOutput({tag, ".underflow"},    32'(underflow),    32'(modelUnf));
`endif
    endtask

    // Drive one clock cycle of requests, advance the model, then check all outputs.
    task automatic applyStimulus(input logic wr, input logic [DATA_W-1:0] d, input logic rd, input string tag);
        int n;
        bit wrOk;
        bit rdOk;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        n       = modelQ.size();
        wrOk    = wr && (n < DEPTH);
        rdOk    = rd && (n > 0);
`ifdef SYNC_FIFO_ERR_EN
        if (wr && n == DEPTH) modelOvf = 1'b1;
        else if (err_clr)     modelOvf = 1'b0;
        if (rd && n == 0)     modelUnf = 1'b1;
        else if (err_clr)     modelUnf = 1'b0;
`endif
        @(posedge clk);
        #1;
        expValid = rdOk;
        if (rdOk) lastData = modelQ.pop_front();
        if (wrOk) modelQ.push_back(d);
        checkAll(tag);
    endtask

    task automatic applyReset(input int cycles, input logic wr, input logic rd);
        rst     = 1'b1;
        wr_en   = wr;
        rd_en   = rd;
        wr_data = 8'hEE;
        repeat (cycles) @(posedge clk);
        #1;
        modelQ.delete();
        lastData = '0;
        expValid = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
        modelOvf = 1'b0;
        modelUnf = 1'b0;
`endif
        checkAll("reset");
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        int wrProb;
        int rdProb;
        rst      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_data  = '0;
        lastData = '0;
        expValid = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
        err_clr  = 1'b0;
        modelOvf = 1'b0;
        modelUnf = 1'b0;
`endif

        // Reset state.
        applyReset(2, 1'b0, 1'b0);
        checkOutput("t1.empty", 32'(empty), 32'd1);
        checkOutput("t1.count", 32'(count), 32'd0);

        // Fill with 0x00..0xFF, then drain in order.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, "t2.wr");
        checkOutput("t2.full", 32'(full), 32'd1);
        checkOutput("t2.count", 32'(count), 32'd256);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, "t2.rd");
            checkOutput("t2.data", 32'(rd_data), 32'(i));
        end
        checkOutput("t2.empty", 32'(empty), 32'd1);

        // Full with simultaneous read and write: write dropped.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, "t3.fill");
        applyStimulus(1'b1, 8'hAA, 1'b1, "t3.both");
        checkOutput("t3.data", 32'(rd_data), 32'h00);
        checkOutput("t3.count", 32'(count), 32'd255);
        checkOutput("t3.full", 32'(full), 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, "t3.drain");
            checkOutput("t3.drainData", 32'(rd_data), 32'(i));
        end

        // Empty with simultaneous read and write: read dropped, no fall-through.
        applyStimulus(1'b1, 8'h55, 1'b1, "t4.both");
        checkOutput("t4.valid", 32'(rd_valid), 32'd0);
        checkOutput("t4.count", 32'(count), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, "t4.rd");
        checkOutput("t4.data", 32'(rd_data), 32'h55);

        // Almost-full and almost-empty thresholds.
        for (int i = 0; i < 251; i++) applyStimulus(1'b1, 8'(i ^ 8'h5A), 1'b0, "t5.fill");
        checkOutput("t5.af251", 32'(almost_full), 32'd0);
        applyStimulus(1'b1, 8'h77, 1'b0, "t5.fill252");
        checkOutput("t5.af252", 32'(almost_full), 32'd1);
        for (int i = 0; i < 247; i++) applyStimulus(1'b0, 8'h00, 1'b1, "t5.drain");
        checkOutput("t5.ae5", 32'(almost_empty), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, "t5.drain4");
        checkOutput("t5.ae4", 32'(almost_empty), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, "t5.empty");

        // Randomized traffic: fill-heavy, drain-heavy, then balanced phases.
        for (int i = 0; i < 900; i++) begin
            case (i / 300)
                0:       begin wrProb = 100; rdProb = 10;  end
                1:       begin wrProb = 10;  rdProb = 100; end
                default: begin wrProb = 70;  rdProb = 70;  end
            endcase
            applyStimulus(1'($urandom_range(99) < wrProb), 8'($urandom),
                          1'($urandom_range(99) < rdProb), "t6.rand");
        end

        // Mid-stream reset discards contents and beats active requests.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(i + 8'h30), 1'b0, "t6.pre");
        applyReset(1, 1'b1, 1'b1);
        checkOutput("t6.rstCount", 32'(count), 32'd0);
        applyStimulus(1'b1, 8'h3C, 1'b0, "t6.postWr");
        applyStimulus(1'b0, 8'h00, 1'b1, "t6.postRd");
        checkOutput("t6.postData", 32'(rd_data), 32'h3C);

`ifdef SYNC_FIFO_ERR_EN
        // Sticky error flags.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, "t7.fill");
        applyStimulus(1'b1, 8'hBB, 1'b0, "t7.ovf");
        checkOutput("t7.ovfSet", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, "t7.hold");
        checkOutput("t7.ovfHold", 32'(overflow), 32'd1);
        err_clr = 1'b1;
        applyStimulus(1'b1, 8'hBC, 1'b0, "t7.setWins");
        checkOutput("t7.ovfSetWins", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, "t7.clr");
        err_clr = 1'b0;
        checkOutput("t7.ovfClr", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, "t7.drain");
        applyStimulus(1'b0, 8'h00, 1'b1, "t7.unf");
        checkOutput("t7.unfSet", 32'(underflow), 32'd1);
        err_clr = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, "t7.unfClr");
        err_clr = 1'b0;
        checkOutput("t7.unfClr", 32'(underflow), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
